prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that fills the 256-word instruction memory read by the fetch stage, replacing the fixed `$readmemb` image. It accepts a header plus big-endian 32-bit words over a valid/ready byte interface and writes each assembled word to the instruction-memory write port. It holds the CPU core in reset until the image is complete. It sits beside `computer`, between an external host link and the instruction memory.

## Interface
Parameters:
- `WORDS`, default 256: instruction-memory depth. Must be 256; addresses are 8 bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rstd`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` is valid this cycle
- `in_ready`  out  1  loader accepts a byte this cycle; transfer = `in_valid & in_ready` at the rising edge
- `im_addr`  out  8  instruction-memory write address (word index)
- `im_wdata`  out  32  instruction word
- `im_wren`  out  1  active-low write enable, one-cycle pulse
- `cpu_rstd`  out  1  active-low reset to the core; low until the load completes
- `done`  out  1  load completed successfully
- `err`  out  1  load failed (checksum build only)

## Operation
- Stream format: header byte H, then 4×(H+1) data bytes, MSB first per word. With the checksum feature, a trailing checksum byte follows.
- Word count is H+1, so H=0 loads 1 word and H=255 loads 256 words.
- States:
  - IDLE: waits for H; on transfer, latches count, clears address and byte counter, goes to LOAD.
  - LOAD: shifts bytes into a 32-bit assembly register (`{asm[23:0], in_data}`), using a 2-bit byte counter.
    - On the 4th byte, issues a write to the current address, then increments the address.
    - After the write of word H, goes to DONE, or to CHECK when the checksum feature is compiled in.
  - CHECK: accepts one byte; goes to DONE on match, otherwise to ERROR.
  - DONE and ERROR are terminal; leaving them requires `rstd`.
- `in_ready` = 1 in IDLE, LOAD and CHECK; 0 in DONE and ERROR and during reset.
- The loader never stalls inside a load. A write pulse does not deassert `in_ready`, so back-to-back bytes at 1 per cycle are legal.
- Address arithmetic is 8-bit. When H=255 the address counter wraps from 255 to 0 after the final write; this is harmless because the state has already left LOAD.
- Bytes offered while `in_ready`=0 are ignored and not consumed.
- Reset mid-load: all state returns to the reset values. Memory words already written are not erased; the next load overwrites them.

## Timing
- Reset values: state IDLE, `in_ready` 0, `im_addr` 0, `im_wdata` 0, `im_wren` 1, `cpu_rstd` 0, `done` 0, `err` 0.
- `in_ready` rises on the first rising edge after `rstd` deasserts.
- All outputs are registered.
- 4th byte of word k accepted at edge t: during cycle t→t+1, `im_wren`=0, `im_addr`=k and `im_wdata`=the assembled word. The memory captures it at edge t+1.
- Without the checksum feature, `cpu_rstd` and `done` go to 1 at edge t+1, where t is the edge of the final write issue. The core is therefore released after the last word is committed.
- With the checksum feature, `cpu_rstd`/`done` (match) or `err` (mismatch) go to 1 at the edge following checksum acceptance.
- Minimum load time is 1 + 4(H+1) cycles, plus 1 cycle with the checksum feature.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - A running 8-bit XOR covers H and every data byte.
  - The CHECK state expects a trailing byte equal to that XOR.
  - On mismatch the loader enters ERROR with `err`=1, `cpu_rstd` held at 0 and `in_ready`=0.
- Undefined:
  - No CHECK or ERROR state and no XOR register.
  - `err` is tied to 0.
  - DONE follows the last write directly.

## Test plan
- Reset, then send H=0x00 and bytes 12 34 56 78 at 1/cycle -> one `im_wren` pulse with addr 0x00 and data 0x12345678; `cpu_rstd`/`done` rise 1 cycle after the pulse; `in_ready`=0 afterwards.
- H=0x02 with three words, `in_valid` toggled 1/0 every cycle -> writes at addrs 0, 1 and 2 with correct data, no duplicate or missing pulses.
- H=0xFF with 1024 bytes -> 256 writes, last at addr 0xFF; `done`=1; extra bytes after `done` are not accepted.
- Assert `rstd`=0 after the 6th data byte of an H=0x03 load, then reload H=0x00 with AA BB CC DD -> addr 0 holds 0xAABBCCDD; `cpu_rstd` stays 0 through the aborted load.
- `PROG_LOADER_CHECKSUM_EN`: H=0x00, data 01 02 03 04, checksum 0x04 (00^01^02^03^04) -> `done`=1, `err`=0. Repeat with checksum 0x05 -> `err`=1, `cpu_rstd`=0, `in_ready`=0.
- Byte offered with `in_valid`=1 during reset and in the first post-reset cycle -> not consumed; the first accepted byte is taken as the header.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader that fills the 256-word instruction memory and holds the core in reset until done
//
// Ports:
//   clk, rstd           clock, asynchronous active-low reset
//   in_data/in_valid    stream byte and its valid flag
//   in_ready            byte accepted at the edge where in_valid & in_ready
//   im_addr/im_wdata    instruction-memory write address (word index) and word
//   im_wren             active-low one-cycle write strobe
//   cpu_rstd            active-low core reset, released once the image is committed
//   done/err            load finished / load failed (err only in the checksum build)
//
// Stream: header H, then 4*(H+1) bytes, MSB first per word.
// Define PROG_LOADER_CHECKSUM_EN to expect a trailing XOR byte over H and all data bytes.
module prog_loader #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic        im_wren,
  output logic        cpu_rstd,
  output logic        done,
  output logic        err
);
`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
  localparam state_t LOAD_END = CHECK;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam state_t LOAD_END = DONE;
`endif
  localparam logic [7:0] ADDR_MAX = 8'(WORDS - 1);
  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [1:0]  bcnt;
  logic [23:0] shift;
  logic        xfer, last_byte, last_word, ready_nx;
  assign xfer      = in_valid & in_ready;
  assign last_byte = bcnt == 2'd3;
  // im_addr only advances on the edge after a write, so it still names the word being assembled
  assign last_word = im_addr == cnt || im_addr == ADDR_MAX;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign ready_nx = state_nx != DONE && state_nx != ERROR;
`else
  assign ready_nx = state_nx != DONE;
  assign err      = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = xfer ? LOAD : IDLE;
      LOAD:    state_nx = xfer && last_byte && last_word ? LOAD_END : LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK:   state_nx = !xfer ? CHECK : in_data == csum ? DONE : ERROR;
`endif
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      im_addr  <= 8'd0;
      im_wdata <= 32'd0;
      im_wren  <= 1'b1;
      cpu_rstd <= 1'b0;
      done     <= 1'b0;
      cnt      <= 8'd0;
      bcnt     <= 2'd0;
      shift    <= 24'd0;
    end else begin
      state    <= state_nx;
      in_ready <= ready_nx;
      im_wren  <= !(state == LOAD && xfer && last_byte);
      // released one edge after entering DONE, i.e. after the final word is captured
      cpu_rstd <= state == DONE;
      done     <= state == DONE;
      if (state == IDLE && xfer) begin
        cnt     <= in_data;
        im_addr <= 8'd0;
        bcnt    <= 2'd0;
      end else if (!im_wren) begin
        im_addr <= im_addr + 8'd1;
      end
      if (state == LOAD && xfer) begin
        shift <= {shift[15:0], in_data};
        bcnt  <= bcnt + 2'd1;
        if (last_byte) im_wdata <= {shift, in_data};
      end
    end
  end
`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      csum <= 8'd0;
      err  <= 1'b0;
    end else begin
      err <= state == ERROR;
      if (xfer && state == IDLE) csum <= in_data;
      else if (xfer && state == LOAD) csum <= csum ^ in_data;
    end
  end
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven loads with a write scoreboard plus reset/abort corner sequences
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, im_wren, cpu_rstd, done, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0;
  logic [7:0]  last_addr;
  logic [39:0] exp_q[$];
  logic [31:0] mem [256];

  prog_loader dut (
    .clk(clk), .rstd(rstd), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_addr(im_addr), .im_wdata(im_wdata), .im_wren(im_wren), .cpu_rstd(cpu_rstd),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!im_wren) mem[im_addr] <= im_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstd && im_wren === 1'b0) begin
      wr_cnt++;
      last_addr = im_addr;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", im_addr, im_wdata);
      end else begin
        chk("write", {im_addr, im_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic reset_dut(input logic [7:0] junk);
    in_valid = 1'b1;
    in_data  = junk;
    rstd     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {in_ready, im_wren, cpu_rstd, done, err, im_addr, im_wdata},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0});
    rstd = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", in_ready, 1);
    exp_q.delete();
  endtask

  task automatic load(input logic [7:0] h, input logic [31:0] seed, input bit tog, input bit bad_cs);
    logic [31:0] w;
    logic [7:0]  x;
    wr_cnt = 0;
    send(h);
    x = h;
    for (int k = 0; k <= int'(h); k++) begin
      w = seed + 32'(k) * 32'h01020305;
      exp_q.push_back({8'(k), w});
      for (int b = 3; b >= 0; b--) begin
        if (k == int'(h) && b == 0) chk("cpu_rstd_in_load", {cpu_rstd, done}, 0);
        send(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
        if (k == int'(h) && b == 0) begin
          chk("last_pulse", im_wren, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
          chk("check_ready", in_ready, 1);
          if (tog) begin in_valid = 1'b0; @(negedge clk); end
          send(bad_cs ? x ^ 8'h01 : x);
          chk("cs_ready_drop", {in_ready, done, err}, 0);
          @(negedge clk);
          chk("cs_result", {cpu_rstd, done, err, in_ready}, {!bad_cs, !bad_cs, bad_cs, 1'b0});
`else
          chk("pre_done", {in_ready, cpu_rstd, done}, 0);
          @(negedge clk);
          chk("done_rise", {cpu_rstd, done, err, in_ready}, {1'b1, 1'b1, 1'b0, 1'b0});
          if (bad_cs) chk("no_cs_build", 0, 0);
`endif
        end else if (tog) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
    end
    in_data  = 8'hEE;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("extra_ignored", {in_ready, exp_q.size() == 0}, {1'b0, 1'b1});
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  h;
    logic [31:0] seed;
    bit          tog;
    int          n_wr;
    logic [7:0]  last;
  } vec_t;

  initial begin
    vec_t v[4];
    v[0] = '{8'h00, 32'h12345678, 1'b0, 1,   8'h00};
    v[1] = '{8'h02, 32'hA0B1C2D3, 1'b1, 3,   8'h02};
    v[2] = '{8'hFF, 32'h00000100, 1'b0, 256, 8'hFF};
    v[3] = '{8'h05, 32'hFEDCBA98, 1'b1, 6,   8'h05};
    for (int i = 0; i < 4; i++) begin
      reset_dut(8'h77);
      load(v[i].h, v[i].seed, v[i].tog, 1'b0);
      chk("wr_count", wr_cnt, v[i].n_wr);
      chk("last_addr", last_addr, v[i].last);
    end
    reset_dut(8'h03);
    send(8'h03);
    exp_q.push_back({8'h00, 32'h11223344});
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    chk("abort_cpu_rstd", {cpu_rstd, done}, 0);
    in_valid = 1'b0;
    rstd = 1'b0;
    @(negedge clk);
    chk("abort_cpu_rstd_rst", {cpu_rstd, exp_q.size() == 0}, {1'b0, 1'b1});
    reset_dut(8'h00);
    load(8'h00, 32'hAABBCCDD, 1'b0, 1'b0);
    @(negedge clk);
    chk("mem0_reload", mem[0], 32'hAABBCCDD);
`ifdef PROG_LOADER_CHECKSUM_EN
    reset_dut(8'h00);
    load(8'h00, 32'h01020304, 1'b0, 1'b0);
    reset_dut(8'h00);
    load(8'h00, 32'h01020304, 1'b0, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
